// File: rtl/disp_pkg.sv
// Shared constants and grant encodings for the
// multiplexed display scheduler.
package disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int MSG_LEN = 20;
  localparam int MSG_W = 4 * MSG_LEN;
  localparam int MAX_OFS = MSG_LEN - NUM_DIGITS;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [2:0] {
    G_TIME = 3'b001,
    G_SET  = 3'b010,
    G_MSG  = 3'b100
  } grant_e;

  function automatic logic [3:0] nib8(
    logic [31:0] w,
    logic [2:0]  d
  );
    return w[{d, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/disp_scan_sched_if.sv
// Requester and display-side signal bundle for
// disp_scan_sched.
interface disp_scan_sched_if;
  import disp_pkg::*;

  logic             req_time;
  logic [31:0]      time_data;
  logic             req_set;
  logic [31:0]      set_data;
  logic [2:0]       set_cursor;
  logic             req_msg;
  logic [MSG_W-1:0] msg_data;
  logic [2:0]       grant;
  logic [7:0]       an;
  logic [3:0]       sc;
  logic             msg_done;

  modport master (
    output req_time,
    output time_data,
    output req_set,
    output set_data,
    output set_cursor,
    output req_msg,
    output msg_data,
    input  grant,
    input  an,
    input  sc,
    input  msg_done
  );

  modport slave (
    input  req_time,
    input  time_data,
    input  req_set,
    input  set_data,
    input  set_cursor,
    input  req_msg,
    input  msg_data,
    output grant,
    output an,
    output sc,
    output msg_done
  );

endinterface

// File: rtl/disp_scan_sched_scan_timebase.sv
// Digit-slot timebase: divides clk into scan slots and
// walks the digit index 0..7.
module scan_timebase #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] d,
  output logic       slot_adv,
  output logic       frame_end
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;

  assign slot_adv = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_adv && (d == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      d <= '0;
    end else if (slot_adv) begin
      cnt <= '0;
      d <= d + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/disp_scan_sched.sv
// Display arbiter: grants the 8-digit display at frame
// boundaries and drives scan, scroll and cursor blink.
module disp_scan_sched
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int SCROLL_DIV = 64,
  parameter int BLINK_DIV  = 32
) (
  input logic              clk,
  input logic              reset,
  disp_scan_sched_if.slave bus
);

  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int OW = $clog2(MAX_OFS + 1);

  logic [2:0]       d;
  logic             slot_adv;
  logic             frame_end;
  grant_e           grant_q;
  grant_e           grant_n;
  logic [MSG_W-1:0] msg_q;
  logic [MSG_W-1:0] msg_sh;
  logic [OW-1:0]    ofs;
  logic [SW-1:0]    scnt;
  logic [BW-1:0]    bcnt;
  logic             blink_on;
  logic             msg_armed;
  logic             scroll_wrap;
  logic             blink_wrap;
  logic             done;
  logic [4:0]       idx;
  logic [3:0]       sc_n;
  logic [7:0]       an_q;
  logic [3:0]       sc_q;
  logic             unused_ok;

  scan_timebase #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .slot_adv  (slot_adv),
    .frame_end (frame_end)
  );

  // time readout is the idle owner, so its request is informational
  assign unused_ok = bus.req_time ^ slot_adv;

  assign scroll_wrap = (scnt == SW'(SCROLL_DIV - 1));
  assign blink_wrap = (bcnt == BW'(BLINK_DIV - 1));
  assign done = frame_end && !reset
             && (grant_q == G_MSG)
             && (ofs == OW'(MAX_OFS))
             && scroll_wrap;

  always_comb begin
    grant_n = G_TIME;
    if (grant_q == G_MSG && !done) begin
      grant_n = G_MSG;
    end else if (bus.req_msg && msg_armed && !done) begin
      grant_n = G_MSG;
    end else if (bus.req_set) begin
      grant_n = G_SET;
    end else begin
      grant_n = G_TIME;
    end
  end

  // digit d shows char (ofs + 7 - d); shift it to the top nibble
  assign idx = 5'(ofs) + 5'd7 - 5'(d);
  assign msg_sh = msg_q << {idx, 2'b00};

  always_comb begin
    sc_n = BLANK;
    unique case (1'b1)
      grant_q[2]: sc_n = msg_sh[MSG_W-1 -: 4];
      grant_q[1]: sc_n = (d == bus.set_cursor && !blink_on)
                       ? BLANK : nib8(bus.set_data, d);
      grant_q[0]: sc_n = nib8(bus.time_data, d);
      default:    sc_n = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= G_TIME;
      an_q <= 8'hFF;
      sc_q <= BLANK;
      msg_q <= '0;
      ofs <= '0;
      scnt <= '0;
      bcnt <= '0;
      blink_on <= 1'b1;
      msg_armed <= 1'b1;
    end else begin
      an_q <= ~(8'h01 << d);
      sc_q <= sc_n;
      if (!bus.req_msg) begin
        msg_armed <= 1'b1;
      end else if (done) begin
        msg_armed <= 1'b0;
      end
      if (frame_end) begin
        grant_q <= grant_n;
        if (grant_n == G_MSG && grant_q != G_MSG) begin
          msg_q <= bus.msg_data;
          ofs <= '0;
          scnt <= '0;
        end else if (grant_q == G_MSG) begin
          if (scroll_wrap) begin
            scnt <= '0;
            if (ofs != OW'(MAX_OFS)) begin
              ofs <= ofs + OW'(1);
            end
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        if (grant_n == G_SET && grant_q != G_SET) begin
          bcnt <= '0;
          blink_on <= 1'b1;
        end else if (grant_q == G_SET) begin
          if (blink_wrap) begin
            bcnt <= '0;
            blink_on <= !blink_on;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
      end
    end
  end

  assign bus.grant = grant_q;
  assign bus.an = an_q;
  assign bus.sc = sc_q;
  assign bus.msg_done = done;

endmodule
